// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-context register file and its clear engine.
package rf_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_CTX = 4;

    typedef enum logic {IDLE, CLEAR} clr_state_t;
    typedef logic [$clog2(DEF_NUM_CTX)-1:0] ctx_t;
endpackage

// File: rtl/rf_clear_engine.sv
// Background bank-clear sequencer: zeroes one entry of an inactive bank per cycle.
module rf_clear_engine
    import rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTX_W  = $clog2(DEF_NUM_CTX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic [CTX_W-1:0]  clr_ctx,
    input  logic [CTX_W-1:0]  ctx_active,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_err,
    output logic              clr_start,
    output logic              clr_we,
    output logic [CTX_W-1:0]  clr_bank,
    output logic [ADDR_W-1:0] clr_idx
);
    clr_state_t        state_q, state_d;
    logic [CTX_W-1:0]  bank_q, bank_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        clr_start = 1'b0;
        case (state_q)
            IDLE: begin
                // The active bank is compared as it stands before any same-edge switch.
                if (clr_req) begin
                    if (clr_ctx != ctx_active) begin
                        clr_start = 1'b1;
                        state_d   = CLEAR;
                        bank_d    = clr_ctx;
                        idx_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                err_d = clr_req;
                idx_d = idx_q + 1'b1;
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = (state_q == CLEAR);
    assign clr_bank = bank_q;
    assign clr_idx  = idx_q;
    assign clr_done = done_q;
    assign clr_err  = err_q;
endmodule

// File: rtl/ctx_reg_file.sv
// Multi-context register file: NUM_CTX banks, one active, combinational reads with
// write bypass, single-cycle context switch and a background bank clear.
module ctx_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_CTX  = DEF_NUM_CTX,
    parameter int CTX_W    = $clog2(NUM_CTX),
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CTX_SWITCH,
    input  logic [CTX_W-1:0]  CTX_SEL,
    input  logic              CLR_REQ,
    input  logic [CTX_W-1:0]  CLR_CTX,
    output logic [CTX_W-1:0]  CTX_ACTIVE,
    output logic              BUSY,
    output logic              CLR_DONE,
    output logic              ERR
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NUM_CTX][DEPTH];
    logic [CTX_W-1:0]  ctx_q;
    logic              sw_err_q;
    logic              busy, clr_done, clr_err, clr_start, clr_we;
    logic [CTX_W-1:0]  clr_bank;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_en;
    logic              sw_reject;

    rf_clear_engine #(
        .ADDR_W (ADDR_W),
        .CTX_W  (CTX_W)
    ) u_clear (
        .clk        (CLK),
        .rst_n      (RESET),
        .clr_req    (CLR_REQ),
        .clr_ctx    (CLR_CTX),
        .ctx_active (ctx_q),
        .busy       (busy),
        .clr_done   (clr_done),
        .clr_err    (clr_err),
        .clr_start  (clr_start),
        .clr_we     (clr_we),
        .clr_bank   (clr_bank),
        .clr_idx    (clr_idx)
    );

    assign wr_en = WRITE && !((ZERO_REG != 0) && (INADDRESS == '0));

    // A switch may never land on the bank being cleared, including one whose clear starts this edge.
    assign sw_reject = CTX_SWITCH && ((busy && (CTX_SEL == clr_bank)) ||
                                      (clr_start && (CTX_SEL == CLR_CTX)));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctx_q    <= '0;
            sw_err_q <= 1'b0;
        end else begin
            sw_err_q <= sw_reject;
            if (CTX_SWITCH && !sw_reject)
                ctx_q <= CTX_SEL;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int c = 0; c < NUM_CTX; c++)
                for (int i = 0; i < DEPTH; i++)
                    regs[c][i] <= '0;
        end else begin
            if (wr_en)
                regs[ctx_q][INADDRESS] <= IN;
            if (clr_we)
                regs[clr_bank][clr_idx] <= '0;
        end
    end

    always_comb begin
        OUT1 = regs[ctx_q][OUT1ADDRESS];
        if (wr_en && (INADDRESS == OUT1ADDRESS))
            OUT1 = IN;
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0))
            OUT1 = '0;
    end

    always_comb begin
        OUT2 = regs[ctx_q][OUT2ADDRESS];
        if (wr_en && (INADDRESS == OUT2ADDRESS))
            OUT2 = IN;
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0))
            OUT2 = '0;
    end

    assign CTX_ACTIVE = ctx_q;
    assign BUSY       = busy;
    assign CLR_DONE   = clr_done;
    assign ERR        = sw_err_q | clr_err;
endmodule

// File: tb/tb_ctx_reg_file.sv
// Randomised bench for ctx_reg_file against an array-level reference model.
module tb_ctx_reg_file;
    import rf_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NC    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic [AW-1:0] waddr, ra1, ra2;
    logic          we;
    logic [DW-1:0] q1, q2;
    logic          sw;
    ctx_t          sel;
    logic          creq;
    ctx_t          cctx;
    ctx_t          act;
    logic          busy, done, err;

    always #5 clk = ~clk;

    ctx_reg_file dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .IN          (din),
        .INADDRESS   (waddr),
        .WRITE       (we),
        .OUT1ADDRESS (ra1),
        .OUT2ADDRESS (ra2),
        .OUT1        (q1),
        .OUT2        (q2),
        .CTX_SWITCH  (sw),
        .CTX_SEL     (sel),
        .CLR_REQ     (creq),
        .CLR_CTX     (cctx),
        .CTX_ACTIVE  (act),
        .BUSY        (busy),
        .CLR_DONE    (done),
        .ERR         (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain arrays; a clear is "m_rem entries still to zero".
    logic [31:0] m [NC][DEPTH];
    int          m_act, m_bank, m_rem;
    bit          m_done, m_err;

    task automatic mdl_reset();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < DEPTH; i++)
                m[c][i] = 32'h0;
        m_act = 0; m_bank = 0; m_rem = 0; m_done = 0; m_err = 0;
    endtask

    function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
        if (we && waddr == a) return din;
        return m[m_act][a];
    endfunction

    task automatic mdl_edge();
        bit clr_start, sw_ok;
        clr_start = creq && (m_rem == 0) && (int'(cctx) != m_act);
        sw_ok     = sw && !((m_rem > 0) && (int'(sel) == m_bank))
                       && !(clr_start && (sel == cctx));
        m_err  = (sw && !sw_ok) || (creq && !clr_start);
        m_done = 0;
        if (we && waddr != 0) m[m_act][waddr] = din;
        if (m_rem > 0) begin
            m[m_bank][DEPTH - m_rem] = 32'h0;
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end
        if (clr_start) begin
            m_bank = int'(cctx);
            m_rem  = DEPTH;
        end
        if (sw_ok) m_act = int'(sel);
    endtask

    task automatic idle();
        we = 0; sw = 0; creq = 0;
        din = $urandom; waddr = AW'($urandom); ra1 = AW'($urandom); ra2 = AW'($urandom);
        sel = ctx_t'($urandom); cctx = ctx_t'($urandom);
    endtask

    // Called just after a negedge with inputs set: check, clock, advance model.
    task automatic cycle();
        #1;
        chk("out1", q1, m_rd(ra1));
        chk("out2", q2, m_rd(ra2));
        chk("ctx_active", 32'(act), 32'(m_act));
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("clr_done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic do_switch(input int c);
        idle(); sw = 1; sel = ctx_t'(c); cycle();
    endtask

    initial begin
        int  cnt;
        bit  seen;
        rst_n = 0;
        idle();
        mdl_reset();
        @(negedge clk);
        #1;
        chk("rst_active", 32'(act), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1;
        @(negedge clk);

        // Reset values visible after release.
        idle(); ra1 = 1; ra2 = 31; #1;
        chk("rst_x1", q1, 32'h0);
        chk("rst_x31", q2, 32'h0);
        cycle();

        // Bypass and x0 behaviour.
        idle(); we = 1; waddr = 5; din = 32'hDEADBEEF; ra1 = 5; #1;
        chk("bypass", q1, 32'hDEADBEEF);
        cycle();
        idle(); we = 1; waddr = 0; din = 32'h1234; ra1 = 0; cycle();
        idle(); ra1 = 0; ra2 = 5; #1;
        chk("x0_read", q1, 32'h0);
        chk("x5_stored", q2, 32'hDEADBEEF);
        cycle();

        // Bank isolation across switches.
        do_switch(2);
        idle(); ra1 = 5; #1;
        chk("ctx2_x5", q1, 32'h0);
        cycle();
        idle(); we = 1; waddr = 5; din = 32'hCAFE0001; cycle();
        do_switch(0);
        idle(); ra1 = 5; #1;
        chk("ctx0_x5", q1, 32'hDEADBEEF);
        cycle();

        // Fill ctx1, clear it from ctx0, measure busy length.
        do_switch(1);
        for (int i = 1; i < DEPTH; i++) begin
            idle(); we = 1; waddr = AW'(i); din = $urandom | 32'h1; cycle();
        end
        do_switch(0);
        idle(); creq = 1; cctx = 1; cycle();
        cnt = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            idle(); #1;
            if (busy) cnt++;
            if (done) seen = 1;
            cycle();
        end
        chk("busy_len", 32'(cnt), 32'd32);
        chk("done_seen", 32'(seen), 32'h1);
        do_switch(1);
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle(); ra1 = AW'(2 * i); ra2 = AW'(2 * i + 1); #1;
            chk("ctx1_clr_a", q1, 32'h0);
            chk("ctx1_clr_b", q2, 32'h0);
            cycle();
        end

        // Rejections during a clear of ctx1.
        do_switch(0);
        idle(); creq = 1; cctx = 1; cycle();
        do_switch(1);
        idle(); #1;
        chk("sw_rej_err", 32'(err), 32'h1);
        chk("sw_rej_act", 32'(act), 32'h0);
        creq = 1; cctx = 0; cycle();
        idle(); #1;
        chk("clr_rej_err", 32'(err), 32'h1);
        chk("clr_rej_busy", 32'(busy), 32'h1);
        cycle();
        for (int k = 0; k < 40 && m_rem > 0; k++) begin
            idle(); cycle();
        end

        // Reset in the middle of clearing ctx3.
        do_switch(3);
        for (int i = 1; i < DEPTH; i++) begin
            idle(); we = 1; waddr = AW'(i); din = $urandom | 32'h1; cycle();
        end
        do_switch(0);
        idle(); creq = 1; cctx = 3; cycle();
        for (int k = 0; k < 10; k++) begin
            idle(); cycle();
        end
        rst_n = 0; #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_active", 32'(act), 32'h0);
        mdl_reset();
        idle();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < NC; c++) begin
            do_switch(c);
            for (int i = 0; i < DEPTH / 2; i++) begin
                idle(); ra1 = AW'(2 * i); ra2 = AW'(2 * i + 1); #1;
                chk("arst_zero_a", q1, 32'h0);
                chk("arst_zero_b", q2, 32'h0);
                cycle();
            end
        end
        do_switch(0);
        idle(); creq = 1; cctx = 2; cycle();
        idle(); #1;
        chk("post_rst_busy", 32'(busy), 32'h1);
        cycle();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            idle();
            we    = 1'($urandom_range(0, 1));
            ra1   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
            ra2   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
            sw    = ($urandom_range(0, 11) == 0);
            creq  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ctx_reg_file.md
Name: ctx_reg_file

Overview:
Parametrised multi-context register file for the RISC-V core. It holds NUM_CTX independent banks of 2**ADDR_W registers, each DATA_W bits wide, and one bank is active at a time. Reads are combinational, with write-to-read bypass. Context switching completes in a single cycle, and a background clear engine zeroes an inactive bank one entry per cycle, so the OS context-switch path never stalls the pipeline. Replaces the single-bank 32x32 register file in the decode stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_CTX, 4, number of context banks; must be a power of two, 2 or more
CTX_W, $clog2(NUM_CTX), derived context index width; not to be overridden
ZERO_REG, 1, 1 = index 0 reads as zero and ignores writes in every bank

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  asynchronous, active-low reset
IN  in  DATA_W  write data
INADDRESS  in  ADDR_W  write index, in the active bank
WRITE  in  1  write enable
OUT1ADDRESS  in  ADDR_W  read port 1 index
OUT2ADDRESS  in  ADDR_W  read port 2 index
OUT1  out  DATA_W  read port 1 data, combinational
OUT2  out  DATA_W  read port 2 data, combinational
CTX_SWITCH  in  1  one-cycle request to change the active bank
CTX_SEL  in  CTX_W  target bank for CTX_SWITCH
CLR_REQ  in  1  one-cycle request to zero a bank
CLR_CTX  in  CTX_W  bank to zero
CTX_ACTIVE  out  CTX_W  current active bank
BUSY  out  1  clear engine running
CLR_DONE  out  1  one-cycle pulse when a clear finishes
ERR  out  1  one-cycle pulse when a request is rejected

Behaviour:
Reset (RESET=0, asynchronous):
- All entries in all banks = 0.
- CTX_ACTIVE=0, state=IDLE, BUSY=0, CLR_DONE=0, ERR=0.
- OUT1/OUT2 therefore read 0.

Read path:
- OUTn = bank[CTX_ACTIVE][OUTnADDRESS].
- Bypass: if WRITE=1 and INADDRESS==OUTnADDRESS (and the index is non-zero when ZERO_REG=1), OUTn = IN in the same cycle.
- ZERO_REG=1: any read of index 0 returns 0.

Write path:
- On posedge with WRITE=1, bank[CTX_ACTIVE][INADDRESS] <= IN.
- Index 0 writes are discarded when ZERO_REG=1.

Context switch:
- On posedge with CTX_SWITCH=1, CTX_ACTIVE <= CTX_SEL.
- A write issued in the same cycle goes to the old bank.
- Reads in the following cycle come from the new bank.
- Rejected when BUSY=1 and CTX_SEL equals the bank being cleared: CTX_ACTIVE is unchanged and ERR pulses the next cycle.
- CTX_SEL == CTX_ACTIVE is a legal no-op.

Clear FSM, states IDLE and CLEAR; registers clr_bank (CTX_W bits) and clr_idx (ADDR_W bits):
- IDLE -> CLEAR on CLR_REQ=1 with CLR_CTX != CTX_ACTIVE. Latch clr_bank=CLR_CTX, clr_idx=0. BUSY=1 from the next cycle.
- CLR_REQ with CLR_CTX == CTX_ACTIVE: ignored, ERR pulse.
- CLR_REQ while in CLEAR: ignored, ERR pulse.
- Compare CLR_CTX against CTX_ACTIVE as it stands before any same-edge switch.
- CLEAR: each cycle, bank[clr_bank][clr_idx] <= 0 and clr_idx increments.
- When clr_idx == 2**ADDR_W-1, that entry is zeroed, the FSM returns to IDLE and CLR_DONE pulses in the next cycle.
- Total latency: 2**ADDR_W cycles of BUSY=1 (32 at defaults).
- The cleared bank is never the active bank, so core writes and clear writes never collide.

Simultaneous CTX_SWITCH and CLR_REQ:
- Both are evaluated against pre-edge state.
- Both may be accepted in the same edge if the banks differ.

ERR rules:
- ERR is a single pulse even if two rejections occur in the same cycle.

Reset during CLEAR:
- Aborts immediately; everything returns to reset values.

Decomposition:
- Package rf_pkg: DATA_W/ADDR_W/NUM_CTX defaults, the clear-FSM state enum (IDLE, CLEAR), and a typedef for the context index.
- One natural sub-module, rf_clear_engine: owns the FSM, clr_bank, clr_idx, BUSY, CLR_DONE, and the clear-side ERR. It outputs a per-cycle clear write strobe, bank and index.
- The top level holds the array, the read/bypass muxes and the switch logic.

Test Plan:
1. Reset release, then read x1 and x31 -> OUT1=OUT2=0, CTX_ACTIVE=0, BUSY=0.
2. ctx0: WRITE x5=32'hDEADBEEF while OUT1ADDRESS=5 -> OUT1=DEADBEEF in the same cycle (bypass). Write x0=32'h1234, read x0 -> 0.
3. ctx0 x5=DEADBEEF; switch to ctx2 -> x5 reads 0. Write ctx2 x5=32'hCAFE0001, switch back to ctx0 -> x5 reads DEADBEEF.
4. Fill ctx1 with nonzero values, CLR_REQ CLR_CTX=1 from ctx0 -> BUSY high exactly 32 cycles, then CLR_DONE pulse. Switch to ctx1 -> all 32 entries read 0. ctx0 contents unchanged throughout.
5. While clearing ctx1: CTX_SWITCH to 1 -> ERR pulse, CTX_ACTIVE unchanged. CLR_REQ CLR_CTX=0 (the active bank) -> ERR pulse, no clear.
6. Drive RESET low at clr_idx=10 during a clear of ctx3 -> BUSY=0 asynchronously and all banks 0. After release, a new CLR_REQ is accepted normally.
